// File: rtl/risc_fetch_buffer.sv
// risc_fetch_buffer: instruction prefetch buffer between a synchronous ROM and
// the controller. It issues one ROM read per cycle while the FIFO has room,
// keeps the returned words tagged with their address, and supports branch
// redirects and halting.
// Optional build macro: RISC_FETCH_STALL_CNT_EN builds the saturating stall
// counter. Without it, stall_count is tied to zero.
module risc_fetch_buffer #(
  parameter int         DEPTH    = 4,
  parameter logic [5:0] RESET_PC = 6'd0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [5:0]  address_to_rom,
  output logic        enable_to_rom,
  input  logic [15:0] data_from_rom,
  output logic        instr_valid,
  output logic [15:0] instr_data,
  output logic [5:0]  instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [5:0]  redirect_addr,
  input  logic        halt_req,
  output logic [15:0] stall_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = CW + 1;

  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_HALT} state_e;

  typedef struct packed {
    logic [5:0]  pc;
    logic [15:0] data;
  } entry_t;

  state_e          state_q;
  logic [5:0]      pc_q;
  logic            en_q;
  logic [5:0]      addr_q;
  logic            rsp_q;
  logic [5:0]      rsp_pc_q;

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q, count_d;

  logic [OW-1:0]   occ;
  logic            strobe;
  logic            push;
  logic            pop;
  entry_t          head;

  // Buffered entries plus reads whose data has not landed yet. A read is
  // outstanding for two cycles: the strobe cycle (en_q) and the data cycle
  // (rsp_q), so both must reserve a slot.
  assign occ    = OW'(count_q) + OW'(en_q) + OW'(rsp_q);
  assign strobe = (state_q == S_RUN) && !redirect_valid && !halt_req &&
                  (occ < OW'(DEPTH));

  // The data cycle of a read coincides with FLUSH for reads issued before a
  // redirect, so those words are dropped; a redirect also drops the word
  // arriving in its own cycle.
  assign push = rsp_q && (state_q != S_FLUSH) && !redirect_valid;
  assign pop  = instr_valid && instr_ready && !redirect_valid;

  assign enable_to_rom  = en_q;
  assign address_to_rom = addr_q;

  // Empty FIFO presents zeros rather than stale storage.
  assign head        = mem_q[rd_ptr_q];
  assign instr_valid = (count_q != '0);
  assign instr_data  = instr_valid ? head.data : 16'h0000;
  assign instr_pc    = instr_valid ? head.pc   : 6'd0;

  // Occupancy next-state: simultaneous push and pop cancel out.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Fetch FSM with the registered ROM strobe/address and the read pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_RUN;
      pc_q     <= RESET_PC;
      en_q     <= 1'b0;
      addr_q   <= 6'd0;
      rsp_q    <= 1'b0;
      rsp_pc_q <= 6'd0;
    end else begin
      en_q     <= strobe;
      rsp_q    <= en_q;
      rsp_pc_q <= addr_q;
      if (strobe) begin
        addr_q <= pc_q;
        pc_q   <= pc_q + 6'd1;
      end
      case (state_q)
        S_RUN: begin
          if (redirect_valid) begin
            state_q <= S_FLUSH;
            pc_q    <= redirect_addr;
          end else if (halt_req) begin
            state_q <= S_HALT;
          end
        end
        S_FLUSH: begin
          if (redirect_valid) begin
            state_q <= S_FLUSH;
            pc_q    <= redirect_addr;
          end else begin
            state_q <= halt_req ? S_HALT : S_RUN;
          end
        end
        S_HALT: begin
          if (redirect_valid) begin
            state_q <= S_FLUSH;
            pc_q    <= redirect_addr;
          end else if (!halt_req) begin
            state_q <= S_RUN;
          end
        end
        default: state_q <= S_RUN;
      endcase
    end
  end

  // FIFO pointers and occupancy; a redirect empties the buffer outright.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect_valid) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage: the returned word is tagged with the address it was read from.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{pc: rsp_pc_q, data: data_from_rom};
  end

`ifdef RISC_FETCH_STALL_CNT_EN
  logic [15:0] stall_q;

  // Count cycles the controller was ready but had nothing to take.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= 16'h0000;
    end else if (instr_ready && !instr_valid && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_risc_fetch_buffer.sv
// Bench for risc_fetch_buffer: directed phases for reset, latency, fill limit,
// redirect, PC wrap, halt and mid-stream reset, followed by a randomized phase
// checked against an instruction-stream model (sequential PCs from the last
// redirect target, data taken from the ROM image).
module tb_risc_fetch_buffer;

  localparam int         DEPTH    = 4;
  localparam logic [5:0] RESET_PC = 6'd0;

  logic        clk;
  logic        reset;
  logic [5:0]  address_to_rom;
  logic        enable_to_rom;
  logic [15:0] data_from_rom;
  logic        instr_valid;
  logic [15:0] instr_data;
  logic [5:0]  instr_pc;
  logic        instr_ready;
  logic        redirect_valid;
  logic [5:0]  redirect_addr;
  logic        halt_req;
  logic [15:0] stall_count;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] rom [64];
  logic [15:0] rom_q;
  logic [15:0] exp_stall;

  risc_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .address_to_rom (address_to_rom),
    .enable_to_rom  (enable_to_rom),
    .data_from_rom  (data_from_rom),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .halt_req       (halt_req),
    .stall_count    (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM: data for a strobe is on the bus during the next cycle.
  always @(posedge clk) if (enable_to_rom) rom_q <= rom[address_to_rom];
  assign data_from_rom = rom_q;

  // Stall reference: ready-but-empty cycles, saturating, cleared by reset.
`ifdef RISC_FETCH_STALL_CNT_EN
  always @(posedge clk or negedge reset) begin
    if (!reset) exp_stall <= 16'h0000;
    else if (instr_ready && !instr_valid && exp_stall != 16'hFFFF)
      exp_stall <= exp_stall + 16'd1;
  end
`else
  assign exp_stall = 16'h0000;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_en(input int max, input string tag);
    for (int i = 0; i < max && !enable_to_rom; i++) step();
    chk(tag, enable_to_rom, 1);
  endtask

  task automatic wait_valid(input int max, input string tag);
    for (int i = 0; i < max && !instr_valid; i++) step();
    chk(tag, instr_valid, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          strobes;
    int          pops;
    logic [5:0]  exp_pc;
    logic        prev_halt, prev_rdr, prev2_rdr;

    for (int a = 0; a < 64; a++) rom[a] = 16'(a) + 16'h0100;
    reset = 1'b0; instr_ready = 1'b1; redirect_valid = 1'b0;
    redirect_addr = 6'd0; halt_req = 1'b0;

    // Reset state
    step(); step();
    chk("rst_en",    enable_to_rom, 0);
    chk("rst_addr",  address_to_rom, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_data",  instr_data, 0);
    chk("rst_pc",    instr_pc, 0);
    chk("rst_stall", stall_count, 0);

    // Release with ready=1: strobes 0,1,2; first word two edges after strobe
    reset = 1'b1;
    step();
    chk("a_en1",   enable_to_rom, 1);
    chk("a_addr1", address_to_rom, 0);
    chk("a_val1",  instr_valid, 0);
    step();
    chk("a_addr2", address_to_rom, 1);
    chk("a_val2",  instr_valid, 0);
    step();
    chk("a_addr3", address_to_rom, 2);
    chk("a_val3",  instr_valid, 1);
    chk("a_pc3",   instr_pc, 0);
    chk("a_data3", instr_data, 16'h0100);
    for (int i = 1; i < 7; i++) begin
      step();
      chk("a_stream_val",  instr_valid, 1);
      chk("a_stream_pc",   instr_pc, i);
      chk("a_stream_data", instr_data, 16'(i) + 16'h0100);
    end
    chk("a_stall", stall_count, exp_stall);

    // Fill with ready=0: exactly DEPTH strobes, then in-order drain
    reset = 1'b0; instr_ready = 1'b0;
    step();
    reset = 1'b1;
    strobes = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (enable_to_rom) strobes++;
    end
    chk("b_strobes", strobes, DEPTH);
    chk("b_en_off",  enable_to_rom, 0);
    chk("b_addr_hold", address_to_rom, DEPTH - 1);
    chk("b_full_val",  instr_valid, 1);
    instr_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("b_drain_pc",   instr_pc, i);
      chk("b_drain_data", instr_data, 16'(i) + 16'h0100);
      step();
    end

    // Redirect with a read in flight: stale words never surface
    wait_en(10, "c_wait_en");
    redirect_valid = 1'b1; redirect_addr = 6'h2A;
    step();
    redirect_valid = 1'b0;
    chk("c_flush_val", instr_valid, 0);
    chk("c_flush_en",  enable_to_rom, 0);
    wait_valid(10, "c_wait_val");
    chk("c_pc",   instr_pc, 6'h2A);
    chk("c_data", instr_data, 16'h012A);
    step();
    chk("c_pc_next", instr_pc, 6'h2B);

    // PC wrap 62, 63, 0
    redirect_valid = 1'b1; redirect_addr = 6'h3E;
    step();
    redirect_valid = 1'b0;
    wait_valid(10, "d_wait_val");
    chk("d_pc62", instr_pc, 6'h3E);
    step();
    chk("d_val63", instr_valid, 1);
    chk("d_pc63",  instr_pc, 6'h3F);
    step();
    chk("d_val0",  instr_valid, 1);
    chk("d_pc0",   instr_pc, 6'h00);
    chk("d_data0", instr_data, 16'h0100);

    // Halt with two reads outstanding: they land, drain, then nothing more
    instr_ready = 1'b0; redirect_valid = 1'b1; redirect_addr = 6'h10;
    step();
    redirect_valid = 1'b0;
    wait_en(10, "e_wait_en");
    step();
    chk("e_en2", enable_to_rom, 1);
    halt_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("e_halt_no_strobe", enable_to_rom, 0);
    end
    chk("e_val",  instr_valid, 1);
    chk("e_pc",   instr_pc, 6'h10);
    chk("e_data", instr_data, 16'h0110);
    instr_ready = 1'b1;
    step();
    chk("e_val2", instr_valid, 1);
    chk("e_pc2",  instr_pc, 6'h11);
    step();
    chk("e_empty", instr_valid, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("e_idle_val", instr_valid, 0);
      chk("e_idle_en",  enable_to_rom, 0);
    end
    chk("e_stall", stall_count, exp_stall);
    halt_req = 1'b0;
    wait_valid(10, "e_resume_val");
    chk("e_resume_pc", instr_pc, 6'h12);

    // Reset mid-stream with a read in flight
    wait_en(10, "g_wait_en");
    reset = 1'b0;
    #1;
    chk("g_en",    enable_to_rom, 0);
    chk("g_addr",  address_to_rom, 0);
    chk("g_val",   instr_valid, 0);
    chk("g_data",  instr_data, 0);
    chk("g_pc",    instr_pc, 0);
    chk("g_stall", stall_count, 0);
    for (int a = 0; a < 64; a++) rom[a] = 16'($urandom);
    step(); step();
    reset = 1'b1;
    wait_valid(10, "g_wait_val");
    chk("g_first_pc",   instr_pc, RESET_PC);
    chk("g_first_data", instr_data, rom[RESET_PC]);

    // Randomized traffic against the stream model
    exp_pc = RESET_PC; pops = 0;
    prev_halt = 1'b0; prev_rdr = 1'b0; prev2_rdr = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (prev_halt || prev_rdr || prev2_rdr) chk("r_no_strobe", enable_to_rom, 0);
      instr_ready    = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_addr  = 6'($urandom);
      if ($urandom_range(0, 9) == 0) halt_req = ~halt_req;
      if (instr_valid) begin
        chk("r_pc",   instr_pc, exp_pc);
        chk("r_data", instr_data, rom[exp_pc]);
      end
      if (redirect_valid) exp_pc = redirect_addr;
      else if (instr_valid && instr_ready) begin
        exp_pc = exp_pc + 6'd1;
        pops++;
      end
      prev2_rdr = prev_rdr;
      prev_rdr  = redirect_valid;
      prev_halt = halt_req;
      step();
    end
    chk("r_progress", (pops > 20), 1);
    chk("r_stall", stall_count, exp_stall);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
